serial_adder_ctrl: RTL and testbench

- Bit-serial multi-bit adder built around a single 1-bit full-adder stage.
- The stage has inputs a, b, c_in and outputs c_out, sum.
- Accepts two WIDTH-bit operands and an initial carry, and feeds the stage one bit pair per clock, LSB first.
- Holds the carry in a flip-flop between bits, assembles the sum in a shift register, and presents the WIDTH-bit result and final carry with a one-cycle done pulse.

---
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage iterated LSB-first over WIDTH bits,
// with a carry flop between bits and a registered result plus done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               fa_s, fa_c;
    logic [WIDTH-1:0]   sum_next;

    // Single 1-bit full-adder stage; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        full_add = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;
        {fa_c, fa_s} = full_add(a_sh_q[0], b_sh_q[0], carry_q);
        // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
        sum_next = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_d   = 1'b1;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_next;
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = sum_next;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign c_out   = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: one WIDTH=8 and one WIDTH=1 instance.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       c1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int tests = 0;
    int fails = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum_out(sum8), .c_out(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(c1),
        .busy(busy1), .done(done1), .sum_out(sum1), .c_out(cout1)
    );

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8) begin
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL w8_unexpected_done: got {c,sum}=%h, none expected", {cout8, sum8});
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                if ({cout8, sum8} !== e) begin
                    fails++;
                    $display("FAIL w8_result: got {c,sum}=%h, expected %h", {cout8, sum8}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL w1_unexpected_done: got {c,sum}=%b, none expected", {cout1, sum1});
            end else begin
                logic [1:0] e;
                e = q1.pop_front();
                if ({cout1, sum1} !== e) begin
                    fails++;
                    $display("FAIL w1_result: got {c,sum}=%b, expected %b", {cout1, sum1}, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic push, input logic [8:0] exp);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = a; b8 = b; c8 = c;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    endtask

    task automatic issue1(input logic a, input logic b, input logic c, input logic [1:0] exp);
        @(posedge clk); #1;
        start1 = 1'b1; a1 = a; b1 = b; c1 = c;
        q1.push_back(exp);
        @(posedge clk); #1;
        start1 = 1'b0; a1 = ~a1; b1 = ~b1; c1 = ~c1;
    endtask

    // Waits (bounded) for done, counting busy cycles seen on the way.
    task automatic wait8(input string name, input int exp_busy);
        int n = 0, bc = 0;
        logic got = 1'b0;
        while (n < 30 && !got) begin
            @(negedge clk);
            if (busy8) bc++;
            if (done8) got = 1'b1;
            n++;
        end
        tests++;
        if (!got || (exp_busy >= 0 && bc != exp_busy)) begin
            fails++;
            $display("FAIL %s_timing: done_seen=%0d busy_cycles=%0d, expected done with busy_cycles=%0d",
                     name, got, bc, exp_busy);
        end
    endtask

    task automatic wait1(input string name);
        int n = 0, bc = 0;
        logic got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            if (busy1) bc++;
            if (done1) got = 1'b1;
            n++;
        end
        tests++;
        if (!got || bc != 1 || n != 2) begin
            fails++;
            $display("FAIL %s_timing: done_seen=%0d busy_cycles=%0d waits=%0d, expected 1 busy then done",
                     name, got, bc, n);
        end
    endtask

    logic [1:0] w1_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy8", 32'(busy8), 0);
        check("reset_done8", 32'(done8), 0);
        check("reset_sum8",  32'({cout8, sum8}), 0);
        check("reset_w1",    32'({busy1, done1, cout1, sum1}), 0);
        rst = 1'b0;

        issue8(8'd3, 8'd5, 1'b0, 1'b1, 9'd8);
        wait8("add_3_5", 8);
        issue8(8'd255, 8'd1, 1'b0, 1'b1, 9'h100);
        wait8("add_255_1", 8);
        issue8(8'd255, 8'd255, 1'b1, 1'b1, 9'h1FF);
        wait8("add_255_255_c", 8);
        repeat (3) @(negedge clk);
        check("hold_sum8", 32'({cout8, sum8}), 32'h1FF);
        issue8(8'd0, 8'd0, 1'b1, 1'b1, 9'd1);
        wait8("add_0_0_c", 8);

        // A start pulse mid-SHIFT must be ignored entirely.
        issue8(8'd10, 8'd20, 1'b0, 1'b1, 9'd30);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd100; c8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait8("ignore_start", -1);
        @(negedge clk);
        check("back_to_idle_busy", 32'(busy8), 0);
        repeat (12) @(negedge clk);
        check("no_second_done_sum", 32'({cout8, sum8}), 32'd30);

        // Reset in the middle of an add aborts it and clears the result.
        issue8(8'd200, 8'd100, 1'b0, 1'b0, 9'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy8", 32'(busy8), 0);
        check("abort_out8",  32'({cout8, sum8}), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'({busy8, done8, cout8, sum8}), 0);
        issue8(8'd1, 8'd1, 1'b0, 1'b1, 9'd2);
        wait8("add_1_1", 8);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            issue1(v[2], v[1], v[0], w1_exp[i]);
            wait1($sformatf("w1_case%0d", i));
        end

        repeat (4) @(negedge clk);
        check("w8_queue_drained", 32'(q8.size()), 0);
        check("w1_queue_drained", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
